tdm_demux: RTL and testbench
============================

// Module: tdm_demux
// PURPOSE
//  Time-division demultiplexer: the receive end of a mux-based TDM serial link.
//  Takes one serial bit stream framed by frame_sync.
//  Deserialises NUM_CH slots of DATA_W bits each, MSB first.
//  Steers each completed slot to its own held output register with a 1-cycle valid pulse.
//  Sits between the serial link pins and per-channel consumer logic.
// PARAMETERS
//  NUM_CH   4  number of TDM slots per frame (>=2)
//  DATA_W   8  bits per slot (>=2)
// PORTS
//  clk          in   1              single clock, rising edge
//  rst_n        in   1              asynchronous active-low reset
//  bit_en       in   1              bit strobe; sdata_in/frame_sync sampled only when high
//  sdata_in     in   1              serial data, MSB of each slot first
//  frame_sync   in   1              high with bit_en on bit 0 of slot 0
//  ch_data_out  out  NUM_CH*DATA_W  slot k in bits [k*DATA_W +: DATA_W], registered, held
//  ch_valid     out  NUM_CH         one-hot 1-cycle pulse: slot k just updated
//  frame_done   out  1              1-cycle pulse with ch_valid[NUM_CH-1]
//  sync_err     out  1              1-cycle pulse on framing violation
// BEHAVIOUR
//  - Reset (async assert; deassert synchronised externally):
//    - state=HUNT, counters 0, shift reg 0.
//    - ch_data_out=0, ch_valid=0, frame_done=0, sync_err=0.
//  - Counters: bit_cnt width $clog2(DATA_W), slot_cnt width $clog2(NUM_CH).
//    - Both wrap to 0 explicitly at DATA_W-1 / NUM_CH-1.
//  - bit_en low: all state, counters and shift reg hold; pulse outputs return to 0.
//  - HUNT state:
//    - Ignore bits until bit_en & frame_sync.
//    - That bit is slot 0 bit 0 (MSB): shift it in, bit_cnt=1, go to RECV.
//  - RECV state, each bit_en:
//    - shift reg <= {shift[DATA_W-2:0], sdata_in}; bit_cnt++.
//    - On the bit where bit_cnt==DATA_W-1 (slot complete):
//      - next cycle, slot register slot_cnt <= completed word;
//      - ch_valid[slot_cnt]=1 for that cycle.
//      - Latency: 1 clk after the bit_en cycle carrying the slot LSB.
//    - Last slot completed: frame_done pulses with ch_valid[NUM_CH-1].
//      - state -> EXPECT (next bit must be a frame start).
//  - EXPECT state:
//    - bit_en & frame_sync: treat as slot 0 bit 0, continue in RECV (back-to-back frames).
//    - bit_en & !frame_sync: sync_err pulse, go to HUNT, bit discarded.
//  - frame_sync high in RECV on any bit other than a frame start (mid-frame):
//    - sync_err pulse; partial slot discarded (no ch_valid for it).
//    - Completed slots of this frame stay valid.
//    - This bit restarts at slot 0 bit 0 (RECV, slot_cnt=0, bit_cnt=1).
//  - Untouched channel registers keep their last value; no clearing on error.
//  - Reset mid-frame: immediate return to reset values; partial data lost.
//  - At most one ch_valid bit high in any cycle.
//  - No combinational path from inputs to outputs.
// TESTING (NUM_CH=4, DATA_W=8)
//  1. Reset
//     - rst_n=0 mid-stream: all outputs 0 asynchronously.
//     - After release with no frame_sync: no ch_valid pulses.
//  2. Single frame, bit_en always high
//     - Stimulus: sync + A5,3C,FF,00.
//     - ch_data_out=32'h00FF3CA5.
//     - ch_valid = 0001, 0010, 0100, 1000, each 1 clk after its slot's LSB.
//     - frame_done coincides with 1000.
//  3. Sparse bit_en (high every 3rd clk)
//     - Stimulus: same frame as test 2.
//     - Same data and pulse ordering as test 2; pulses 1 clk after each slot's last strobe.
//  4. Back-to-back frames
//     - Stimulus: frame 11,22,33,44 then immediately 55,66,77,88.
//     - Eight ch_valid pulses, no sync_err.
//     - Final ch_data_out=32'h88776655.
//  5. Missing sync
//     - Stimulus: after a complete frame, next bit has frame_sync=0.
//     - sync_err pulses; further data ignored until the next sync.
//     - Outputs hold the previous frame.
//  6. Early sync
//     - Stimulus: frame_sync on bit 3 of slot 2.
//     - sync_err pulses; no ch_valid[2].
//     - Slots 0 and 1 retain their new values.
//     - Restarted frame DE,AD,BE,EF yields 32'hEFBEADDE.

Source files
------------

// File: rtl/tdm_demux.sv
// Receive end of a TDM serial link: deserialises NUM_CH slots of DATA_W bits
// (MSB first) framed by frame_sync and steers each slot to its own held register.
module tdm_demux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     bit_en,
    input  logic                     sdata_in,
    input  logic                     frame_sync,
    output logic [NUM_CH*DATA_W-1:0] ch_data_out,
    output logic [NUM_CH-1:0]        ch_valid,
    output logic                     frame_done,
    output logic                     sync_err
);

    localparam int BIT_W  = $clog2(DATA_W);
    localparam int SLOT_W = $clog2(NUM_CH);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

    typedef enum logic [1:0] {HUNT, RECV, EXPECT} state_t;

    state_t              state_q, state_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
    // Only the first DATA_W-1 bits of a slot need storing; the LSB arrives live.
    logic [DATA_W-2:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   shifted;
    logic                word_done;
    logic                frame_end;
    logic                framing_err;

    assign shifted = {shift_q, sdata_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            bit_cnt_q  <= '0;
            slot_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            slot_cnt_q <= slot_cnt_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        slot_cnt_d  = slot_cnt_q;
        shift_d     = shift_q;
        word_done   = 1'b0;
        frame_end   = 1'b0;
        framing_err = 1'b0;
        if (bit_en) begin
            unique case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        shift_d    = shifted[DATA_W-2:0];
                        bit_cnt_d  = BIT_W'(1);
                        slot_cnt_d = '0;
                        state_d    = RECV;
                    end
                end
                RECV: begin
                    shift_d = shifted[DATA_W-2:0];
                    // Any sync inside a frame restarts it at slot 0 bit 0.
                    if (frame_sync) begin
                        framing_err = 1'b1;
                        bit_cnt_d   = BIT_W'(1);
                        slot_cnt_d  = '0;
                    end else if (bit_cnt_q == LAST_BIT) begin
                        word_done = 1'b1;
                        bit_cnt_d = '0;
                        if (slot_cnt_q == LAST_SLOT) begin
                            frame_end  = 1'b1;
                            slot_cnt_d = '0;
                            state_d    = EXPECT;
                        end else begin
                            slot_cnt_d = slot_cnt_q + SLOT_W'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
                EXPECT: begin
                    if (frame_sync) begin
                        shift_d    = shifted[DATA_W-2:0];
                        bit_cnt_d  = BIT_W'(1);
                        slot_cnt_d = '0;
                        state_d    = RECV;
                    end else begin
                        framing_err = 1'b1;
                        state_d     = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Completed words land in their channel register one clock after the LSB strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_data_out <= '0;
            ch_valid    <= '0;
            frame_done  <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            ch_valid   <= '0;
            frame_done <= frame_end;
            sync_err   <= framing_err;
            for (int k = 0; k < NUM_CH; k++) begin
                if (word_done && (slot_cnt_q == SLOT_W'(k))) begin
                    ch_data_out[k*DATA_W +: DATA_W] <= shifted;
                    ch_valid[k]                     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: frame-position reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_tdm_demux;

    localparam int NUM_CH     = 4;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = NUM_CH * DATA_W;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     bit_en;
    logic                     sdata_in;
    logic                     frame_sync;
    logic [NUM_CH*DATA_W-1:0] ch_data_out;
    logic [NUM_CH-1:0]        ch_valid;
    logic                     frame_done;
    logic                     sync_err;

    tdm_demux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_en      (bit_en),
        .sdata_in    (sdata_in),
        .frame_sync  (frame_sync),
        .ch_data_out (ch_data_out),
        .ch_valid    (ch_valid),
        .frame_done  (frame_done),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int gap      = 0;
    int valid_cnt = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    logic [NUM_CH-1:0] valid_log[$];

    // Reference model: pos is the bit index within the current frame,
    // -1 while hunting, FRAME_BITS when a full frame has just ended.
    int                pos;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] m_data[NUM_CH];
    logic [NUM_CH-1:0] m_valid;
    logic              m_done;
    logic              m_err;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pos = -1;
        word = '0;
        for (int i = 0; i < NUM_CH; i++) m_data[i] = '0;
        m_valid = '0;
        m_done  = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step();
        int slot;
        m_valid = '0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        if (bit_en) begin
            if (pos < 0) begin
                if (frame_sync) begin pos = 1; word = DATA_W'(sdata_in); end
            end else if (pos == FRAME_BITS) begin
                if (frame_sync) begin pos = 1; word = DATA_W'(sdata_in); end
                else begin m_err = 1'b1; pos = -1; end
            end else if (frame_sync) begin
                m_err = 1'b1;
                pos   = 1;
                word  = DATA_W'(sdata_in);
            end else begin
                word = DATA_W'((word << 1) | DATA_W'(sdata_in));
                pos++;
                if (pos % DATA_W == 0) begin
                    slot          = pos / DATA_W - 1;
                    m_data[slot]  = word;
                    m_valid[slot] = 1'b1;
                    m_done        = (slot == NUM_CH - 1);
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Compare on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("cycle_outputs",
                     64'({ch_data_out, ch_valid, frame_done, sync_err}),
                     64'({m_data[3], m_data[2], m_data[1], m_data[0], m_valid, m_done, m_err}));
            if (ch_valid != '0) begin
                valid_cnt++;
                valid_log.push_back(ch_valid);
            end
            if (frame_done) done_cnt++;
            if (sync_err)   err_cnt++;
        end
    end

    task automatic send_bit(input logic sd, input logic fs);
        repeat (gap) begin
            @(negedge clk);
            bit_en     = 1'b0;
            sdata_in   = 1'($urandom);
            frame_sync = 1'($urandom);
        end
        @(negedge clk);
        bit_en     = 1'b1;
        sdata_in   = sd;
        frame_sync = fs;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input logic sync_first, input int nbits);
        for (int i = DATA_W - 1; i >= DATA_W - nbits; i--)
            send_bit(w[i], sync_first && (i == DATA_W - 1));
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                              input logic [DATA_W-1:0] w2, input logic [DATA_W-1:0] w3);
        send_word(w0, 1'b1, DATA_W);
        send_word(w1, 1'b0, DATA_W);
        send_word(w2, 1'b0, DATA_W);
        send_word(w3, 1'b0, DATA_W);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bit_en     = 1'b0;
            sdata_in   = 1'b0;
            frame_sync = 1'b0;
        end
    endtask

    initial begin
        int v0, d0, e0;
        logic [15:0] order;
        rst_n = 1'b0; bit_en = 1'b0; sdata_in = 1'b0; frame_sync = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", 64'({ch_data_out, ch_valid, frame_done, sync_err}), 64'd0);
        rst_n = 1'b1;

        // No sync after reset: nothing may be received.
        v0 = valid_cnt;
        repeat (24) send_bit(1'($urandom), 1'b0);
        idle(2);
        check_eq("no_sync_valid", 64'(valid_cnt - v0), 64'd0);

        // Reset in the middle of a frame.
        send_word(8'hA5, 1'b1, DATA_W);
        send_word(8'h3C, 1'b0, DATA_W);
        send_word(8'h77, 1'b0, 4);
        @(negedge clk); #2; rst_n = 1'b0; #1;
        check_eq("midstream_reset", 64'({ch_data_out, ch_valid, frame_done, sync_err}), 64'd0);
        idle(2);
        rst_n = 1'b1;

        // Single frame, bit_en always high.
        gap = 0; v0 = valid_cnt; d0 = done_cnt;
        valid_log.delete();
        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h00);
        idle(3);
        check_eq("single_frame_data", 64'(ch_data_out), 64'h00FF3CA5);
        order = (valid_log.size() == 4) ?
                {valid_log[0], valid_log[1], valid_log[2], valid_log[3]} : 16'h0;
        check_eq("single_frame_order", 64'(order), 64'h1248);
        check_eq("single_frame_done", 64'(done_cnt - d0), 64'd1);

        // Sparse bit strobe: one in three clocks.
        gap = 2; v0 = valid_cnt;
        valid_log.delete();
        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h00);
        idle(3);
        check_eq("sparse_data", 64'(ch_data_out), 64'h00FF3CA5);
        order = (valid_log.size() == 4) ?
                {valid_log[0], valid_log[1], valid_log[2], valid_log[3]} : 16'h0;
        check_eq("sparse_order", 64'(order), 64'h1248);

        // Back-to-back frames.
        gap = 0; v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h11, 8'h22, 8'h33, 8'h44);
        send_frame(8'h55, 8'h66, 8'h77, 8'h88);
        idle(3);
        check_eq("b2b_valid_count", 64'(valid_cnt - v0), 64'd8);
        check_eq("b2b_no_err", 64'(err_cnt - e0), 64'd0);
        check_eq("b2b_data", 64'(ch_data_out), 64'h88776655);

        // Missing sync after a complete frame.
        v0 = valid_cnt; e0 = err_cnt;
        send_bit(1'b1, 1'b0);
        repeat (40) send_bit(1'($urandom), 1'b0);
        idle(3);
        check_eq("missing_sync_err", 64'(err_cnt - e0), 64'd1);
        check_eq("missing_sync_valid", 64'(valid_cnt - v0), 64'd0);
        check_eq("missing_sync_hold", 64'(ch_data_out), 64'h88776655);

        // Early sync on bit 3 of slot 2.
        v0 = valid_cnt; e0 = err_cnt;
        valid_log.delete();
        send_word(8'h01, 1'b1, DATA_W);
        send_word(8'h02, 1'b0, DATA_W);
        send_word(8'hC3, 1'b0, 3);
        idle(3);
        check_eq("early_partial", 64'(ch_data_out), 64'h88770201);
        send_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF);
        idle(3);
        check_eq("early_err", 64'(err_cnt - e0), 64'd1);
        check_eq("early_valid_count", 64'(valid_cnt - v0), 64'd6);
        check_eq("early_data", 64'(ch_data_out), 64'hEFBEADDE);

        // Randomised traffic: mostly clean frames, some stray syncs and gaps.
        for (int n = 0; n < 60; n++) begin
            gap = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0)
                send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            else
                repeat ($urandom_range(1, 20))
                    send_bit(1'($urandom), ($urandom_range(0, 9) == 0));
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
